// File: rtl/recovery_restore_sequencer.sv
// Restore sequencer for the TMR recovery register file: on a restore request it copies
// recovery entries START_IDX..NUM_REGS-1 into the core register file while the core is stalled.
module recovery_restore_sequencer #(
    parameter int NUM_REGS  = 32,
    parameter int START_IDX = 1,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              restore_req,
    output logic [31:0]       rec_A,
    input  logic [DATA_W-1:0] rec_RD,
    output logic              rf_WE,
    output logic [4:0]        rf_A,
    output logic [DATA_W-1:0] rf_WD,
    output logic              core_stall,
    output logic              busy,
    output logic              done,
    output logic [5:0]        restore_cnt
);

    localparam logic [5:0] FIRST_IDX = 6'(START_IDX);
    localparam logic [5:0] LAST_IDX  = 6'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                req_q;
    logic                start_s;

    logic [31:0]         rec_a_q, rec_a_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_a_q, rf_a_d;
    logic [DATA_W-1:0]   rf_wd_q, rf_wd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    assign start_s = restore_req & ~req_q;

    // Next-state logic for the copy walk; start edges are honoured only from IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    idx_d   = FIRST_IDX;
                    cnt_d   = 6'd0;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                data_d  = rec_RD;
                state_d = WRITE;
            end
            WRITE: begin
                cnt_d = cnt_q + 6'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = READ;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so every port comes straight from a flop.
    always_comb begin
        rec_a_d = 32'd0;
        rf_we_d = 1'b0;
        rf_a_d  = 5'd0;
        rf_wd_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            READ: begin
                rec_a_d = 32'(idx_d);
                busy_d  = 1'b1;
            end
            WRITE: begin
                rf_we_d = 1'b1;
                rf_a_d  = idx_d[4:0];
                rf_wd_d = data_d;
                busy_d  = 1'b1;
            end
            FINISH: begin
                done_d = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q <= IDLE;
            idx_q   <= FIRST_IDX;
            data_q  <= '0;
            cnt_q   <= 6'd0;
            req_q   <= 1'b0;
            rec_a_q <= 32'd0;
            rf_we_q <= 1'b0;
            rf_a_q  <= 5'd0;
            rf_wd_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            req_q   <= restore_req;
            rec_a_q <= rec_a_d;
            rf_we_q <= rf_we_d;
            rf_a_q  <= rf_a_d;
            rf_wd_q <= rf_wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rec_A       = rec_a_q;
    assign rf_WE       = rf_we_q;
    assign rf_A        = rf_a_q;
    assign rf_WD       = rf_wd_q;
    assign busy        = busy_q;
    assign core_stall  = busy_q;
    assign done        = done_q;
    assign restore_cnt = cnt_q;

endmodule

// File: tb/tb_recovery_restore_sequencer.sv
// Bench for recovery_restore_sequencer: directed and random request/reset patterns,
// every cycle compared against a phase-based reference model of the restore walk.
module tb_recovery_restore_sequencer;

    localparam int NUM_REGS  = 32;
    localparam int START_IDX = 1;
    localparam int DATA_W    = 32;
    localparam int N_ENT     = NUM_REGS - START_IDX;
    localparam int LASTP     = 2 * N_ENT + 1;

    logic              clk;
    logic              rst_in;
    logic              restore_req;
    logic [31:0]       rec_A;
    logic [DATA_W-1:0] rec_RD;
    logic              rf_WE;
    logic [4:0]        rf_A;
    logic [DATA_W-1:0] rf_WD;
    logic              core_stall;
    logic              busy;
    logic              done;
    logic [5:0]        restore_cnt;

    logic [DATA_W-1:0] rec_mem [0:NUM_REGS-1];

    int checks = 0;
    int errors = 0;

    // Model: m_p is cycles since the start edge (0 = idle), m_cnt entries written.
    int                m_p    = 0;
    int                m_cnt  = 0;
    logic              m_prev = 1'b0;
    logic [DATA_W-1:0] m_cap  = '0;
    logic              last_rstn = 1'b1;
    int                n_writes = 0;
    int                n_dones  = 0;

    recovery_restore_sequencer #(
        .NUM_REGS (NUM_REGS),
        .START_IDX(START_IDX),
        .DATA_W   (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .restore_req(restore_req),
        .rec_A      (rec_A),
        .rec_RD     (rec_RD),
        .rf_WE      (rf_WE),
        .rf_A       (rf_A),
        .rf_WD      (rf_WD),
        .core_stall (core_stall),
        .busy       (busy),
        .done       (done),
        .restore_cnt(restore_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rec_RD = (rec_A < 32'(NUM_REGS)) ? rec_mem[rec_A[4:0]] : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (m_p=%0d)", tag, got, exp, m_p);
        end
    endtask

    task automatic check_outputs();
        logic exp_we;
        logic exp_rd;
        exp_we = (m_p != 0) && (m_p % 2 == 0);
        exp_rd = (m_p % 2 == 1) && (m_p < LASTP);
        chk("busy", 64'(busy), 64'(m_p != 0));
        chk("core_stall", 64'(core_stall), 64'(m_p != 0));
        chk("done", 64'(done), 64'(m_p == LASTP));
        chk("rf_WE", 64'(rf_WE), 64'(exp_we));
        chk("rec_A", 64'(rec_A), exp_rd ? 64'(START_IDX + (m_p - 1) / 2) : 64'd0);
        chk("restore_cnt", 64'(restore_cnt), 64'(m_cnt));
        if (exp_rd) begin
            m_cap = rec_mem[START_IDX + (m_p - 1) / 2];
        end
        if (exp_we) begin
            chk("rf_A", 64'(rf_A), 64'(START_IDX + (m_p - 2) / 2));
            chk("rf_WD", 64'(rf_WD), 64'(m_cap));
        end
        if (!last_rstn) begin
            chk("rst_rf_A", 64'(rf_A), 64'd0);
            chk("rst_rf_WD", 64'(rf_WD), 64'd0);
        end
        if (rf_WE) n_writes++;
        if (done) n_dones++;
    endtask

    // One clock: apply inputs, advance the model at the edge, then compare.
    task automatic cyc(input logic req, input logic rstn);
        restore_req = req;
        rst_in      = rstn;
        last_rstn   = rstn;
        @(posedge clk);
        if (!rstn) begin
            m_p    = 0;
            m_cnt  = 0;
            m_prev = 1'b0;
        end else begin
            if (m_p == 0) begin
                if (req && !m_prev) begin
                    m_p   = 1;
                    m_cnt = 0;
                end
            end else begin
                if (m_p % 2 == 0) m_cnt++;
                if (m_p == LASTP) m_p = 0;
                else m_p++;
            end
            m_prev = req;
        end
        @(negedge clk);
        // Disturb the entry being written: output must keep the value captured in READ.
        if (m_p != 0 && m_p % 2 == 0) begin
            rec_mem[START_IDX + (m_p - 2) / 2] = $urandom;
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n, input int p1, input int p2, input int rst_at);
        for (int k = 0; k < n; k++) begin
            cyc((k == 0) || (k == p1) || (k == p2), k != rst_at);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_REGS; i++) rec_mem[i] = $urandom;
    endtask

    initial begin
        restore_req = 1'b0;
        rst_in      = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) rec_mem[i] = '0;
        rec_mem[1] = 32'd1;
        rec_mem[2] = 32'd5;
        rec_mem[3] = 32'hAAAA_AAAA;

        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1);

        // Directed contents, single pulse, full walk plus idle tail.
        n_writes = 0;
        n_dones  = 0;
        run(70, -1, -1, -1);
        chk("walk1_writes", 64'(n_writes), 64'(N_ENT));
        chk("walk1_dones", 64'(n_dones), 64'd1);

        // Level held high: exactly one sequence.
        fill_random();
        n_writes = 0;
        n_dones  = 0;
        for (int k = 0; k < 200; k++) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        chk("hold_writes", 64'(n_writes), 64'(N_ENT));
        chk("hold_dones", 64'(n_dones), 64'd1);

        // Extra pulses during an active sequence are ignored.
        fill_random();
        n_writes = 0;
        n_dones  = 0;
        run(70, 10, 40, -1);
        chk("extra_writes", 64'(n_writes), 64'(N_ENT));
        chk("extra_dones", 64'(n_dones), 64'd1);

        // Reset mid-sequence, then restart from the first entry.
        fill_random();
        run(30, -1, -1, 20);
        run(70, -1, -1, -1);

        // Back-to-back sequences with a new edge at cycle 66.
        fill_random();
        n_writes = 0;
        n_dones  = 0;
        run(140, 66, -1, -1);
        chk("b2b_writes", 64'(n_writes), 64'(2 * N_ENT));
        chk("b2b_dones", 64'(n_dones), 64'd2);

        // Start edge landing exactly on the FINISH cycle is dropped.
        run(63, -1, -1, -1);
        run(10, -1, -1, -1);

        // Random requests and occasional resets.
        fill_random();
        for (int k = 0; k < 600; k++) begin
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 149) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
